// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR types, default tap masks and the pcounter step function
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } fsm_t;

  localparam int unsigned MAX_WIDTH = 16;

  // Maximal-length masks; bit n-1 is the x^n term.
  function automatic logic [MAX_WIDTH-1:0] default_taps(input int unsigned width);
    case (width)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [MAX_WIDTH-1:0] lfsr_step(
    input logic [MAX_WIDTH-1:0] s,
    input logic [MAX_WIDTH-1:0] taps,
    input int unsigned          width
  );
    logic [MAX_WIDTH-1:0] mask;
    mask = MAX_WIDTH'((32'd1 << width) - 32'd1);
    return {s[MAX_WIDTH-2:0], ^(s & taps)} & mask;
  endfunction

endpackage

// File: rtl/lfsr_decode_if.sv
// rtl/lfsr_decode_if.sv - request/result handshake bundle; err_o present only with LFSR_DECODE_ERR_EN
interface lfsr_decode_if #(
  parameter int unsigned WIDTH = 6
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] state_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] index_o;
`ifdef LFSR_DECODE_ERR_EN
  logic             err_o;
`endif

  modport master (
    output valid_i, state_i, ready_i,
`ifdef LFSR_DECODE_ERR_EN
    input  err_o,
`endif
    input  ready_o, valid_o, index_o
  );

  modport slave (
    input  valid_i, state_i, ready_i,
`ifdef LFSR_DECODE_ERR_EN
    output err_o,
`endif
    output ready_o, valid_o, index_o
  );
endinterface

// File: rtl/lfsr_ref.sv
// rtl/lfsr_ref.sv - registered reference LFSR with load-to-SEED and step enables
module lfsr_ref
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 6,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= WIDTH'(lfsr_step(MAX_WIDTH'(state), MAX_WIDTH'(TAPS), WIDTH));
    end
  end

endmodule

// File: rtl/lfsr_decode.sv
// rtl/lfsr_decode.sv - sequential LFSR state-to-index decoder; LFSR_DECODE_ERR_EN adds err_o and zero short-circuit
module lfsr_decode
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 6,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input logic          clk_i,
  input logic          rst_i,
  lfsr_decode_if.slave bus
);

  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'((1 << WIDTH) - 2);
`ifdef LFSR_DECODE_ERR_EN
  localparam bit ZERO_SHORTCUT = 1'b1;
`else
  localparam bit ZERO_SHORTCUT = 1'b0;
`endif

  fsm_t             fsm;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ref_state;
  logic             accept;
  logic             consume;
  logic             hit;
  logic             miss;

  assign accept  = bus.valid_i && bus.ready_o;
  assign consume = bus.valid_o && bus.ready_i;
  assign hit     = (ref_state == target);
  // Index 2^WIDTH-1 never occurs on the sequence, so all-ones is a safe miss marker.
  assign miss    = (ZERO_SHORTCUT && target == '0) || (cnt == LAST_CNT);

  lfsr_ref #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_ref (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  ((fsm == IDLE) && accept),
    .step  (fsm == SEARCH),
    .state (ref_state)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fsm         <= IDLE;
      bus.ready_o <= 1'b1;
      bus.valid_o <= 1'b0;
      bus.index_o <= '0;
      cnt         <= '0;
      target      <= '0;
`ifdef LFSR_DECODE_ERR_EN
      bus.err_o   <= 1'b0;
`endif
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            target      <= bus.state_i;
            cnt         <= '0;
            bus.ready_o <= 1'b0;
            fsm         <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            bus.index_o <= cnt;
            bus.valid_o <= 1'b1;
`ifdef LFSR_DECODE_ERR_EN
            bus.err_o   <= 1'b0;
`endif
            fsm         <= DONE;
          end else if (miss) begin
            bus.index_o <= '1;
            bus.valid_o <= 1'b1;
`ifdef LFSR_DECODE_ERR_EN
            bus.err_o   <= 1'b1;
`endif
            fsm         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (consume) begin
            bus.valid_o <= 1'b0;
            bus.ready_o <= 1'b1;
            fsm         <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_decode.sv
// tb/tb_lfsr_decode.sv - randomized self-checking bench for lfsr_decode against a sequence-table model
module tb_lfsr_decode;

  localparam int unsigned WIDTH = 6;

  logic clk;
  logic rst_i;
  int   checks;
  int   errors;

  logic [5:0] seq [0:62];
  int         order [0:62];

  lfsr_decode_if #(.WIDTH(WIDTH)) bus ();

  lfsr_decode #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] model_next(input logic [5:0] s);
    logic [5:0] t;
    logic       fb;
    t  = 6'b110000;
    fb = 1'b0;
    for (int b = 0; b < 6; b++) if (t[b]) fb = fb ^ s[b];
    return {s[4:0], fb};
  endfunction

  function automatic int model_index(input logic [5:0] s);
    for (int i = 0; i < 63; i++) if (seq[i] == s) return i;
    return 63;
  endfunction

  function automatic int model_latency(input logic [5:0] s);
    int k;
    k = model_index(s);
    if (k < 63) return k + 1;
`ifdef LFSR_DECODE_ERR_EN
    return 1;
`else
    return 63;
`endif
  endfunction

  task automatic decode(input logic [5:0] s, output logic [5:0] idx, output int lat, output logic err);
    int n;
    n = 0;
    while (!bus.ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_req", bus.ready_o, 1);
    bus.valid_i = 1'b1;
    bus.state_i = s;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.state_i = 6'($urandom);
    lat = 0;
    while (!bus.valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    idx = bus.index_o;
`ifdef LFSR_DECODE_ERR_EN
    err = bus.err_o;
`else
    err = 1'b0;
`endif
    n = $urandom_range(0, 2);
    repeat (n) begin
      @(posedge clk); #1;
    end
    check("held_index", bus.index_o, idx);
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    check("ready_after_consume", bus.ready_o, 1);
    check("valid_after_consume", bus.valid_o, 0);
  endtask

  task automatic run_one(input string tag, input logic [5:0] s);
    logic [5:0] idx;
    int         lat;
    logic       err;
    decode(s, idx, lat, err);
    check({tag, "_index"}, idx, model_index(s) == 63 ? 6'h3F : 6'(model_index(s)));
    check({tag, "_latency"}, lat, model_latency(s));
`ifdef LFSR_DECODE_ERR_EN
    check({tag, "_err"}, err, model_index(s) == 63);
`endif
  endtask

  initial begin
    logic [5:0] s;
    int         n;
    int         j;
    int         tmp;
    checks = 0;
    errors = 0;

    s = 6'd1;
    for (int i = 0; i < 63; i++) begin
      seq[i]   = s;
      s        = model_next(s);
      order[i] = i;
    end

    rst_i       = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.state_i = '0;
    #12;
    check("rst_ready", bus.ready_o, 1);
    check("rst_valid", bus.valid_o, 0);
    check("rst_index", bus.index_o, 0);
`ifdef LFSR_DECODE_ERR_EN
    check("rst_err", bus.err_o, 0);
`endif
    @(posedge clk); #1;
    rst_i = 1'b1;

    run_one("seed", 6'b000001);
    run_one("seq1", 6'b000010);
    run_one("seq4", 6'b010000);
    run_one("seq5", 6'b100001);
    run_one("seq6", 6'b000011);

    for (int i = 62; i > 0; i--) begin
      j        = $urandom_range(0, i);
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 63; i++) run_one("exh", seq[order[i]]);

    run_one("zero", 6'b000000);

    // Backpressure: result must freeze while junk requests are offered.
    bus.valid_i = 1'b1;
    bus.state_i = 6'b100001;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    n = 0;
    while (!bus.valid_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_latency", n, 6);
    for (int c = 0; c < 10; c++) begin
      bus.valid_i = 1'($urandom);
      bus.state_i = 6'($urandom);
      @(posedge clk); #1;
      check("bp_valid", bus.valid_o, 1);
      check("bp_index", bus.index_o, 5);
      check("bp_ready", bus.ready_o, 0);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_idle_valid", bus.valid_o, 0);
      check("bp_idle_ready", bus.ready_o, 1);
    end

    // Asynchronous reset while searching.
    bus.valid_i = 1'b1;
    bus.state_i = 6'b100001;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    @(posedge clk); #1;
    check("mid_searching", bus.ready_o, 0);
    #2 rst_i = 1'b0;
    #1;
    check("mid_rst_valid", bus.valid_o, 0);
    check("mid_rst_ready", bus.ready_o, 1);
    check("mid_rst_index", bus.index_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    run_one("after_rst", 6'b100001);

    for (int i = 0; i < 8; i++) run_one("rand", seq[$urandom_range(0, 62)]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_decode.md
Name: lfsr_decode

Overview:
- Inverse of the LFSR-based pseudo counter: converts a captured WIDTH-bit Fibonacci LFSR state back to its binary sequence index, counted from SEED.
- Sits at the consumer end of the pcounter family. Lets monitors and software read pseudo-counter values as ordinary integers.
- Decoding is a sequential search. An internal reference LFSR steps from SEED until it equals the captured state. A valid/ready handshake is used on both sides.

Parameters:
- WIDTH, 6: LFSR and index width.
- TAPS, 6'b110000: feedback mask. The default is x^6+x^5+1, which must be primitive for WIDTH.
- SEED, 1: index-0 state. Must be nonzero.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted when valid_i&&ready_o.
- state_i  in  WIDTH  LFSR state to decode.
- valid_o  out  1  result valid.
- ready_i  in  1  result consumed when valid_o&&ready_i.
- index_o  out  WIDTH  decoded index.
- err_o  out  1  only with LFSR_DECODE_ERR_EN; result is invalid.

Behaviour:
- Step function: next = {s[WIDTH-2:0], ^(s & TAPS)}. Shift left; the new LSB is the XOR of the tapped bits. This is bit-identical to the pcounter step.
- Reset (rst_i=0, async): FSM=IDLE, ready_o=1, valid_o=0, index_o=0, err_o=0, ref=SEED, cnt=0, target=0.
- FSM IDLE:
  - ready_o=1.
  - On handshake: target<=state_i, ref<=SEED, cnt<=0, go to SEARCH.
- FSM SEARCH:
  - ready_o=0.
  - Each edge, if ref==target: index_o<=cnt, go to DONE.
  - Otherwise: ref<=step(ref), cnt<=cnt+1.
  - If cnt==2^WIDTH-2 and there is no match (target is not on the sequence, e.g. all-zero): index_o<=all-ones, err flag set, go to DONE.
- FSM DONE:
  - valid_o=1; index_o/err_o held stable.
  - On valid_o&&ready_i, go to IDLE; ready_o is high the next cycle.
- Latency: a state at index k produces valid_o high k+1 cycles after the accept edge. Worst case is 2^WIDTH-1 cycles.
- Throughput: one request in flight. No new accept is possible in the same cycle a result is consumed, so ready_o rises on the cycle after.
- cnt is WIDTH bits and never wraps: the search is bounded at 2^WIDTH-2.
- state_i is sampled only at handshake. Later changes are ignored.
- valid_o, index_o and err_o must not change while valid_o=1 and ready_i=0.
- Reset asserted mid-SEARCH or mid-DONE: the result is discarded and all outputs return to reset values immediately.

Optional Feature:
- Macro: LFSR_DECODE_ERR_EN.
- Defined:
  - err_o port exists.
  - err_o=1 with index_o=all-ones for all-zero or unreachable states.
  - err_o=0 for every successful decode.
  - All-zero input is short-circuited: DONE on the first SEARCH edge, latency 1.
- Undefined:
  - No err_o port.
  - All-zero input runs the full bounded search and returns index_o=all-ones, latency 2^WIDTH-1.
  - Index 2^WIDTH-1 is never a legal result, so all-ones is unambiguous.

Decomposition:
- Package lfsr_pkg:
  - FSM state encoding (IDLE=0, SEARCH=1, DONE=2).
  - Default TAPS constants per WIDTH 3..16.
  - Step function shared with pcounter.
- Sub-module lfsr_ref: registered reference LFSR with load (to SEED) and step enables, async active-low reset.

Test Plan:
- Reset, WIDTH=6 defaults:
  - Stimulus: state_i=6'b000001 accepted.
  - Required: valid_o after 1 cycle, index_o=0.
- Sequence check:
  - 6'b000010 -> 1; 6'b010000 -> 4; 6'b100001 -> 5; 6'b000011 -> 6.
  - Latency equals index+1 in each case.
- Exhaustive check:
  - Drive pcounter output at every position of the full 63-state period.
  - Required: index_o matches the position for all 63 states; never all-ones.
- Zero input, state_i=0:
  - With LFSR_DECODE_ERR_EN: err_o=1, index_o=6'h3F, latency 1.
  - Without: index_o=6'h3F, latency 63.
- Backpressure:
  - Stimulus: hold ready_i=0 for 10 cycles in DONE while toggling state_i and valid_i.
  - Required: outputs stable, ready_o=0, no new accept.
- Mid-search reset:
  - Stimulus: pulse rst_i low during SEARCH for state 6'b100001.
  - Required: valid_o=0 and ready_o=1 asynchronously. A fresh request then decodes correctly.
